// File: rtl/icache_resp_if.sv
// Fetch and refill signal bundle for the instruction cache.
// The slave modport is the cache: it answers fetches and drives the refill
// bus. The master modport is its environment: the fetching core plus the
// backing instruction memory.
interface icache_resp_if #(
   parameter int ADDR_W = 32
);
   logic              iCacheReadEn;
   logic [ADDR_W-1:0] iCacheReadAddr;
   logic [31:0]       iCacheReadData;
   logic              iCacheReady;
   logic              memReq;
   logic [ADDR_W-1:0] memAddr;
   logic              memAck;
   logic [31:0]       memData;

   modport slave (
      input  iCacheReadEn, iCacheReadAddr, memAck, memData,
      output iCacheReadData, iCacheReady, memReq, memAddr
   );

   modport master (
      output iCacheReadEn, iCacheReadAddr, memAck, memData,
      input  iCacheReadData, iCacheReady, memReq, memAddr
   );
endinterface

// File: rtl/icache_resp.sv
// Direct-mapped, read-only instruction cache.
// A hit returns the stored word one cycle after the request. A miss refills
// the whole line from backing memory one beat per memAck. The requested word
// is captured as its beat arrives and returned in a single RESPOND cycle.
// A flush seen while busy is remembered and applied on the next IDLE cycle.
module icache_resp #(
   parameter int NUM_LINES      = 16,
   parameter int WORDS_PER_LINE = 4,
   parameter int ADDR_W         = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   output logic         busy,
   icache_resp_if.slave bus
);
   localparam int INDEX_W = $clog2(NUM_LINES);
   localparam int OFF_W   = $clog2(WORDS_PER_LINE);
   localparam int TAG_W   = ADDR_W - INDEX_W - OFF_W - 2;
   localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);

   typedef enum logic [1:0] {IDLE, REFILL, RESPOND} state_t;

   state_t               state;
   logic [NUM_LINES-1:0] valid;
   logic                 flush_pend;
   logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
   logic [31:0]          data_mem [NUM_LINES*WORDS_PER_LINE];

   // Line being refilled, latched when the miss is detected
   logic [INDEX_W-1:0]   line_index;
   logic [TAG_W-1:0]     line_tag;
   logic [OFF_W-1:0]     line_off;
   logic [OFF_W-1:0]     beat;
   logic [31:0]          resp_word;

   // Fields of the incoming fetch address
   logic [OFF_W-1:0]     req_off;
   logic [INDEX_W-1:0]   req_index;
   logic [TAG_W-1:0]     req_tag;
   logic                 hit;
   logic                 beat_ack;
   logic                 unused_byte_bits;

   assign req_off   = bus.iCacheReadAddr[OFF_W+1:2];
   assign req_index = bus.iCacheReadAddr[OFF_W+INDEX_W+1:OFF_W+2];
   assign req_tag   = bus.iCacheReadAddr[ADDR_W-1:ADDR_W-TAG_W];
   assign hit       = valid[req_index] && (tag_mem[req_index] == req_tag);
   assign beat_ack  = (state == REFILL) && bus.memAck;
   assign busy      = (state != IDLE);

   // Fetches are word aligned; the byte-select bits carry no information.
   assign unused_byte_bits = ^bus.iCacheReadAddr[1:0];

   // Line storage: each refill beat writes one word, the last beat the tag.
   // NOTE: data and tag arrays are deliberately left out of reset; the valid
   // bits alone decide whether their contents mean anything, and resetting
   // the arrays would prevent mapping them onto RAM.
   always_ff @(posedge clk) begin
      if (beat_ack) begin
         data_mem[{line_index, beat}] <= bus.memData;
         if (beat == LAST_BEAT) begin
            tag_mem[line_index] <= line_tag;
         end
      end
   end

   // Control FSM with registered fetch and refill outputs.
   // NOTE: every register here is assigned with <= so all of them update
   // from the same pre-edge values; a blocking = would leak a new value into
   // later statements of the same cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state              <= IDLE;
         valid              <= '0;
         flush_pend         <= 1'b0;
         bus.iCacheReady    <= 1'b0;
         bus.iCacheReadData <= '0;
         bus.memReq         <= 1'b0;
         bus.memAddr        <= '0;
         line_index         <= '0;
         line_tag           <= '0;
         line_off           <= '0;
         beat               <= '0;
         resp_word          <= '0;
      end else begin
         bus.iCacheReady <= 1'b0;
         case (state)
            IDLE: begin
               if (flush || flush_pend) begin
                  // A flush cycle never services a fetch.
                  valid      <= '0;
                  flush_pend <= 1'b0;
               end else if (bus.iCacheReadEn) begin
                  if (hit) begin
                     bus.iCacheReady    <= 1'b1;
                     bus.iCacheReadData <= data_mem[{req_index, req_off}];
                  end else begin
                     line_index  <= req_index;
                     line_tag    <= req_tag;
                     line_off    <= req_off;
                     beat        <= '0;
                     bus.memAddr <= {req_tag, req_index, {OFF_W{1'b0}}, 2'b00};
                     bus.memReq  <= 1'b1;
                     state       <= REFILL;
                  end
               end
            end

            REFILL: begin
               if (flush) begin
                  flush_pend <= 1'b1;
               end
               if (bus.memAck) begin
                  beat <= beat + OFF_W'(1);
                  // Only the offset field advances, so the beat address
                  // wraps inside the line instead of carrying into the index.
                  bus.memAddr[OFF_W+1:2] <= beat + OFF_W'(1);
                  if (beat == line_off) begin
                     resp_word <= bus.memData;
                  end
                  if (beat == LAST_BEAT) begin
                     valid[line_index]  <= 1'b1;
                     bus.memReq         <= 1'b0;
                     bus.iCacheReady    <= 1'b1;
                     bus.iCacheReadData <= (beat == line_off) ? bus.memData : resp_word;
                     state              <= RESPOND;
                  end
               end
            end

            RESPOND: begin
               if (flush) begin
                  flush_pend <= 1'b1;
               end
               state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_icache_resp.sv
// Bench for icache_resp. The reference model tracks which line address is
// resident in each cache slot; since backing memory never changes, every
// expected fetch result is simply the backing-memory word at that address.
// Expected responses go into a queue that a monitor drains on iCacheReady,
// and expected refill beat addresses go into a queue that the memory
// responder drains on each memAck.
module tb_icache_resp;
   logic clk;
   logic rst;
   logic flush;
   logic busy;

   icache_resp_if #(.ADDR_W(32)) bus ();

   icache_resp #(
      .NUM_LINES      (16),
      .WORDS_PER_LINE (4),
      .ADDR_W         (32)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .busy  (busy),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   logic [31:0] exp_q[$];
   logic [31:0] exp_mem_q[$];

   // Reference model: residency per slot
   bit          m_valid [16];
   logic [23:0] m_tag   [16];
   int          pending_skip = 0;

   // Memory responder configuration (written by the driver only)
   int gap_cfg     = 1;
   bit gap_rand    = 1'b0;
   bit spurious_en = 1'b0;
   int stall_cfg   = 0;

   // Memory responder status (written by the responder only)
   int ack_total    = 0;
   int last_ack_cyc = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h40:  return 32'h2001_0002;
         32'h44:  return 32'h2022_0002;
         32'h48:  return 32'h2043_0002;
         32'h4C:  return 32'h0022_2020;
         default: return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
      endcase
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
   endtask

   // Response monitor: pops on every ready pulse, checks hold otherwise.
   logic [31:0] held_data = '0;
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            held_data = '0;
         end else if (bus.iCacheReady) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_ready: got data 0x%0h with no request outstanding (cycle %0d)",
                        bus.iCacheReadData, cyc);
            end else begin
               check("resp_data", bus.iCacheReadData, exp_q.pop_front());
            end
            held_data = bus.iCacheReadData;
         end else begin
            check("data_hold", bus.iCacheReadData, held_data);
         end
      end
   end

   // Backing memory responder
   initial begin
      int  wait_cnt   = 0;
      int  line_acks  = 0;
      int  stall_cnt  = 0;
      bit  stall_used = 1'b0;
      bus.memAck  = 1'b0;
      bus.memData = '0;
      forever begin
         @(negedge clk);
         bus.memAck = 1'b0;
         if (!rst) begin
            wait_cnt   = 0;
            line_acks  = 0;
            stall_cnt  = 0;
            stall_used = 1'b0;
         end else if (bus.memReq) begin
            if (stall_cfg > 0 && line_acks == 2 && !stall_used) begin
               stall_cnt  = stall_cfg;
               stall_used = 1'b1;
            end
            if (stall_cnt > 0) begin
               stall_cnt--;
               check("stall_busy", busy, 1);
               check("stall_ready", bus.iCacheReady, 0);
            end else if (wait_cnt > 0) begin
               wait_cnt--;
            end else begin
               if (exp_mem_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_refill: memAddr 0x%0h with no refill expected (cycle %0d)",
                           bus.memAddr, cyc);
               end else begin
                  check("mem_addr", bus.memAddr, exp_mem_q.pop_front());
               end
               bus.memAck   = 1'b1;
               bus.memData  = mem_word(bus.memAddr);
               line_acks++;
               ack_total++;
               last_ack_cyc = cyc;
               wait_cnt     = gap_rand ? int'($urandom_range(0, 2)) : gap_cfg;
            end
         end else begin
            line_acks  = 0;
            stall_used = 1'b0;
            if (spurious_en && $urandom_range(0, 5) == 0) begin
               bus.memAck  = 1'b1;
               bus.memData = $urandom;
            end
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      bus.iCacheReadEn = 1'b0;
      repeat (n) tick();
      pending_skip = (pending_skip > n) ? pending_skip - n : 0;
   endtask

   task automatic do_flush();
      idle(pending_skip);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      model_clear();
   endtask

   // One fetch; flush_beat >= 1 raises flush once that many beats have been acked.
   task automatic fetch(input logic [31:0] addr, input int flush_beat);
      logic [3:0]  idx;
      logic [23:0] tag;
      bit          hit;
      bit          done;
      bit          flushed;
      int          n;
      int          start;
      int          skip;
      idx     = addr[7:4];
      tag     = addr[31:8];
      hit     = m_valid[idx] && (m_tag[idx] == tag);
      done    = 1'b0;
      flushed = 1'b0;
      n       = 0;
      skip    = pending_skip;
      start   = ack_total;
      exp_q.push_back(mem_word({addr[31:2], 2'b00}));
      if (!hit) begin
         for (int k = 0; k < 4; k++) exp_mem_q.push_back({addr[31:4], 4'h0} + 32'(4 * k));
      end
      bus.iCacheReadAddr = addr;
      bus.iCacheReadEn   = 1'b1;
      while (n < 400 && !done) begin
         tick();
         n++;
         flush = 1'b0;
         if (n == 1 + skip) check("miss_detect", bus.memReq, !hit);
         if (bus.iCacheReady) begin
            done = 1'b1;
         end else if (flush_beat > 0 && !flushed && (ack_total - start) == flush_beat) begin
            flush   = 1'b1;
            flushed = 1'b1;
         end
      end
      flush = 1'b0;
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL fetch_timeout: no iCacheReady for address 0x%0h within 400 cycles", addr);
      end else if (hit) begin
         check("hit_latency", n, 1 + skip);
      end else begin
         check("miss_latency", cyc, last_ack_cyc + 1);
      end
      if (!hit) begin
         m_valid[idx] = 1'b1;
         m_tag[idx]   = tag;
      end
      if (flushed) model_clear();
      pending_skip = hit ? 0 : (flushed ? 2 : 1);
   endtask

   // Start a miss, then pull reset once two beats have landed.
   task automatic reset_mid_refill(input logic [31:0] addr);
      int start;
      int n;
      idle(pending_skip);
      for (int k = 0; k < 4; k++) exp_mem_q.push_back({addr[31:4], 4'h0} + 32'(4 * k));
      start              = ack_total;
      n                  = 0;
      bus.iCacheReadAddr = addr;
      bus.iCacheReadEn   = 1'b1;
      while (n < 100 && (ack_total - start) < 2) begin
         tick();
         n++;
      end
      check("reset_setup_busy", busy, 1);
      rst              = 1'b0;
      bus.iCacheReadEn = 1'b0;
      #1;
      check("reset_memreq", bus.memReq, 0);
      check("reset_outputs", {bus.iCacheReady, bus.iCacheReadData, bus.memAddr, busy}, '0);
      exp_mem_q.delete();
      exp_q.delete();
      model_clear();
      pending_skip = 0;
      repeat (3) tick();
      rst = 1'b1;
      tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] addr;
      int          fb;
      rst                = 1'b0;
      flush              = 1'b0;
      bus.iCacheReadEn   = 1'b0;
      bus.iCacheReadAddr = '0;
      model_clear();
      #1;
      check("por_outputs", {bus.iCacheReady, bus.iCacheReadData, bus.memReq, bus.memAddr, busy}, '0);
      repeat (2) tick();
      rst = 1'b1;
      tick();

      // Cold miss with an ack every other cycle, then hits in the same line
      gap_cfg = 1;
      fetch(32'h44, -1);
      fetch(32'h4C, -1);
      fetch(32'h40, -1);
      fetch(32'h48, -1);

      // Conflict on the same slot
      fetch(32'h144, -1);
      fetch(32'h44, -1);

      // Flush in IDLE, then flush during a refill
      do_flush();
      fetch(32'h40, -1);
      fetch(32'h140, 2);
      fetch(32'h140, -1);

      // Memory stalls for 20 cycles mid-refill
      stall_cfg = 20;
      fetch(32'h240, -1);
      stall_cfg = 0;

      // Reset in the middle of a refill
      reset_mid_refill(32'h80);
      fetch(32'h0, -1);
      fetch(32'h80, -1);

      // Randomized traffic over a small address window
      gap_rand    = 1'b1;
      spurious_en = 1'b1;
      for (int i = 0; i < 150; i++) begin
         case ($urandom_range(0, 9))
            0: do_flush();
            1: idle(int'($urandom_range(1, 3)));
            default: begin
               addr = 32'($urandom_range(0, 255)) << 2;
               fb   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : -1;
               fetch(addr, fb);
            end
         endcase
      end
      spurious_en = 1'b0;

      idle(5);
      check("resp_drain", exp_q.size(), 0);
      check("mem_addr_drain", exp_mem_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/icache_resp.md
Name: icache_resp

Overview:
Direct-mapped, read-only instruction cache. It responds to mipsCore fetch requests on the iCacheReadAddr/iCacheReadData interface. On a hit it returns the instruction word from internal line storage. On a miss it refills a whole line from backing instruction memory over a simple req/ack beat handshake, then returns the word. It replaces the stimulus-driven iCacheReadData source in the core top level.

Parameters:
NUM_LINES, 16, number of cache lines; power of two, ≥2; INDEX_W = log2(NUM_LINES)
WORDS_PER_LINE, 4, 32-bit words per line; power of two, ≥2; OFF_W = log2(WORDS_PER_LINE)
ADDR_W, 32, byte address width; TAG_W = ADDR_W - INDEX_W - OFF_W - 2

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-low reset
iCacheReadEn  input  1  fetch request; held with a stable address until iCacheReady
iCacheReadAddr  input  ADDR_W  fetch byte address; bits [1:0] ignored
iCacheReadData  output  32  instruction word; valid when iCacheReady=1
iCacheReady  output  1  one-cycle pulse: the request is complete
flush  input  1  invalidate all lines
memReq  output  1  refill request to backing memory
memAddr  output  ADDR_W  word address of the current refill beat
memAck  input  1  one pulse per beat; memData is valid in the same cycle
memData  input  32  refill data word
busy  output  1  high while the FSM is not in IDLE

Behaviour:
- Address split: offset = addr[OFF_W+1:2], index = addr[OFF_W+INDEX_W+1:OFF_W+2], tag = upper TAG_W bits.
- Storage: data array NUM_LINES×WORDS_PER_LINE×32, tag array, and valid bits. Arrays carry no reset; only the valid bits reset.
- Reset (rst=0, asynchronous):
  - all valid bits = 0, state = IDLE, flush_pend = 0
  - iCacheReady = 0, iCacheReadData = 0, memReq = 0, memAddr = 0, busy = 0
  - Reset mid-refill aborts the refill; the line stays invalid; memReq drops immediately.
- FSM states: IDLE, REFILL, RESPOND.
- IDLE:
  - If flush=1, clear all valid bits this cycle and ignore iCacheReadEn this cycle.
  - Else if iCacheReadEn=1 and the access hits (valid and tag match): in the next cycle iCacheReady=1 and iCacheReadData = stored word. Hit latency is 1 cycle. State stays IDLE.
  - Else if iCacheReadEn=1 and the access misses: latch index, tag and offset; memAddr = {tag, index, 0 offset, 2'b00}; memReq = 1; beat = 0; go to REFILL.
- REFILL:
  - memReq is held at 1.
  - On each memAck: write memData to word[beat]; beat += 1; memAddr += 4.
  - The beat after WORDS_PER_LINE-1 completes the refill: write the tag, set the valid bit, set memReq = 0 in the next cycle, go to RESPOND.
  - memAck while memReq=0 is ignored.
- RESPOND (1 cycle): iCacheReady = 1 and iCacheReadData = refilled word at the latched offset, taken from the beat capture so there is no extra array read. Then go to IDLE.
- Miss latency: 1 cycle (detect) + memory beats + 1 cycle (RESPOND).
- flush during REFILL or RESPOND:
  - Set flush_pend; the refill completes and data is returned normally.
  - On entering IDLE, all valid bits clear (including the just-filled line) and flush_pend clears.
  - iCacheReadEn in that IDLE cycle is not serviced until the next cycle.
- iCacheReady is never high on two consecutive cycles for a miss. For back-to-back hits with a changing address, it may be high every cycle.
- iCacheReadData holds its last value when iCacheReady=0.
- Address wrap: memAddr increments only within the line; no carry out of the offset field.
- busy = (state != IDLE).

Test Plan:
1. Reset: assert rst=0 mid-run -> all outputs 0 immediately; a fetch of 0x0 afterwards misses (memReq=1 the cycle after the request).
2. Cold miss: fetch 0x44; memory acks 4 beats with data 0x20010002, 0x20220002, 0x20430002, 0x00222020, each 2 cycles after the previous -> memAddr steps 0x40, 0x44, 0x48, 0x4C; iCacheReady pulses with data 0x20220002 one cycle after the last ack.
3. Hit: after scenario 2, fetch 0x4C, 0x40, 0x48 on consecutive cycles -> ready each following cycle with 0x00222020, 0x20010002, 0x20430002; memReq stays 0.
4. Conflict: fetch 0x144 (same index as 0x40 with defaults) -> miss and refill from 0x140; a following fetch of 0x44 misses again.
5. Flush: flush in IDLE, then fetch 0x40 -> miss. Flush asserted during beat 2 of a refill -> data still returned; next fetch of the same address misses.
6. Stalled memory: memAck held low 20 cycles mid-refill -> memReq held at 1, iCacheReady stays 0, busy=1 throughout.
